// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter that shares one signed Booth multiplier among NUM_REQ clients.
// Optional WAIT-state watchdog is compiled in with `define BOOTH_ARB_TIMEOUT_EN.
module booth_mult_arbiter #(
    parameter int N              = 4,
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*N-1:0]       rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_err,
    output logic                 mul_start,
    output logic [N-1:0]         mul_a,
    output logic [N-1:0]         mul_b,
    input  logic [2*N-1:0]       mul_data_out,
    input  logic                 mul_done,
    output logic [1:0]           fsm_state
);

    // Encoding is visible on fsm_state: IDLE=0, ISSUE=1, WAIT=2, RESP=3.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] rr;
    logic [ID_W-1:0] id;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] cand;
    logic            grant_found;
    logic            done_q;
    logic            done_evt;
    logic            timeout_hit;
    logic            wait_exit;

    logic [N-1:0] a_arr [NUM_REQ];
    logic [N-1:0] b_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*N +: N];
        assign b_arr[i] = req_b[i*N +: N];
    end

    // A held-high done counts once: only the rising edge is an event.
    assign done_evt  = mul_done & ~done_q;
    assign wait_exit = (state == WAIT) && (done_evt || timeout_hit);

    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant       = cand;
                grant_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Both channels use valid/ready: a transfer happens at a rising clk edge
    // where valid and ready are both high; a request slot is accepted when its
    // req_ready bit is high, and the response is held until rsp_ready.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant] = 1'b1;
                    state_next       = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (done_evt || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mul_start = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr       <= ID_W'(NUM_REQ - 1);
            id       <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= mul_done;
            if (state == IDLE && grant_found) begin
                mul_a <= a_arr[grant];
                mul_b <= b_arr[grant];
                id    <= grant;
                rr    <= grant;
            end
            // A timed-out transaction returns a zero product.
            if (wait_exit) begin
                rsp_data <= done_evt ? mul_data_out : '0;
                rsp_id   <= id;
            end
        end
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (wait_exit) begin
                rsp_err <= ~done_evt;
            end
        end
    end

    // Fires in the TIMEOUT_CYCLES-th WAIT cycle; a coincident done wins.
    assign timeout_hit = (state == WAIT) && !done_evt &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Scoreboard bench for booth_mult_arbiter with a behavioural multiplier model.
// Build with BOOTH_ARB_TIMEOUT_EN defined to exercise the watchdog path.
module tb_booth_mult_arbiter;

    localparam int N      = 4;
    localparam int NR     = 4;
    localparam int ID_W   = 2;
    localparam int TO     = 64;
    localparam int PW     = 2 * N;
    localparam int EW     = 1 + ID_W + PW;
    localparam int LAT    = 4;
    localparam int M_PULSE = 0;
    localparam int M_LEVEL = 1;
    localparam int M_NEVER = 2;
`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*N-1:0] req_a = '0;
    logic [NR*N-1:0] req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [PW-1:0]   rsp_data;
    logic [ID_W-1:0] rsp_id;
    logic            rsp_err;
    logic            mul_start;
    logic [N-1:0]    mul_a;
    logic [N-1:0]    mul_b;
    logic [PW-1:0]   mul_data_out = '0;
    logic            mul_done = 1'b0;
    logic [1:0]      fsm_state;

    int compared = 0;
    int mismatched = 0;

    booth_mult_arbiter #(.N(N), .NUM_REQ(NR), .ID_W(ID_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_data_out(mul_data_out), .mul_done(mul_done), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    function automatic logic [PW-1:0] product(input logic [N-1:0] a, input logic [N-1:0] b);
        int ia;
        int ib;
        ia = $signed(a);
        ib = $signed(b);
        return PW'(ia * ib);
    endfunction

    // ---------------- multiplier model ----------------
    int           done_mode = M_PULSE;
    int           lat = 0;
    logic [N-1:0] op_a = '0;
    logic [N-1:0] op_b = '0;

    always begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            lat      = 0;
            mul_done = 1'b0;
        end else if (mul_start) begin
            lat          = LAT;
            op_a         = mul_a;
            op_b         = mul_b;
            mul_done     = 1'b0;
            mul_data_out = PW'($urandom);
        end else if (lat > 0) begin
            lat--;
            if (lat == 0 && done_mode != M_NEVER) begin
                mul_done     = 1'b1;
                mul_data_out = product(op_a, op_b);
            end
        end else if (done_mode != M_LEVEL) begin
            mul_done     = 1'b0;
            mul_data_out = PW'($urandom);
        end
    end

    // ---------------- random response backpressure ----------------
    bit rand_ready = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- monitor / scoreboard ----------------
    logic [EW-1:0]   exp_q[$];
    logic [EW-1:0]   got;
    int              grant_log[$];
    int              cyc = 0;
    int              last_g = NR - 1;
    int              start_cyc = 0;
    int              mon_g;
    int              acc_count = 0;
    int              rsp_count = 0;
    bit              busy = 1'b0;
    bit              start_due = 1'b0;
    bit              waiting = 1'b0;
    bit              rise_due = 1'b0;
    bit              act_rise;
    bit              exp_rise;
    logic            prev_valid = 1'b0;
    logic            prev_ready = 1'b0;
    logic            done_prev = 1'b0;
    logic [N-1:0]    exp_a = '0;
    logic [N-1:0]    exp_b = '0;
    logic [NR-1:0]   exp_ready;
    logic [PW-1:0]   prev_data = '0;
    logic [PW-1:0]   last_rsp_data = '0;
    logic [ID_W-1:0] prev_id = '0;
    logic            prev_err = 1'b0;
    logic            last_rsp_err = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            acc_count -= exp_q.size();
            exp_q.delete();
            busy       = 1'b0;
            last_g     = NR - 1;
            start_due  = 1'b0;
            waiting    = 1'b0;
            rise_due   = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            // round-robin reference: first valid after the last grant, wrapping
            exp_ready = '0;
            mon_g = -1;
            if (!busy) begin
                for (int k = 1; k <= NR; k++) begin
                    if (mon_g < 0 && req_valid[(last_g + k) % NR]) mon_g = (last_g + k) % NR;
                end
            end
            if (mon_g >= 0) exp_ready[mon_g] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_ready));

            check("mul_start", 64'(mul_start), 64'(start_due));
            if (start_due) begin
                check("mul_a", 64'(mul_a), 64'(exp_a));
                check("mul_b", 64'(mul_b), 64'(exp_b));
                waiting   = 1'b1;
                start_cyc = cyc;
            end
            start_due = 1'b0;

            if (mon_g >= 0) begin
                busy      = 1'b1;
                last_g    = mon_g;
                start_due = 1'b1;
                acc_count++;
                grant_log.push_back(mon_g);
                exp_a = req_a[mon_g*N +: N];
                exp_b = req_b[mon_g*N +: N];
                if (TO_EN && done_mode == M_NEVER)
                    exp_q.push_back({1'b1, ID_W'(mon_g), PW'(0)});
                else
                    exp_q.push_back({1'b0, ID_W'(mon_g), product(exp_a, exp_b)});
            end

            act_rise = rsp_valid && !prev_valid;
            exp_rise = rise_due ||
                       (TO_EN && done_mode == M_NEVER && waiting && (cyc - start_cyc == TO + 1));
            if (act_rise || exp_rise) check("rsp_valid_rise", 64'(act_rise), 64'(exp_rise));
            if (act_rise) waiting = 1'b0;
            rise_due = waiting && !mul_start && mul_done && !done_prev;

            if (prev_valid && !prev_ready) begin
                check("hold_valid", 64'(rsp_valid), 64'(1'b1));
                check("hold_data", 64'(rsp_data), 64'(prev_data));
                check("hold_id", 64'(rsp_id), 64'(prev_id));
                check("hold_err", 64'(rsp_err), 64'(prev_err));
            end

            if (rsp_valid && rsp_ready) begin
                rsp_count++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_rsp: got id %0d data 0x%0h, expected no response", rsp_id, rsp_data);
                end else begin
                    got = exp_q.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(got[PW-1:0]));
                    check("rsp_id", 64'(rsp_id), 64'(got[PW +: ID_W]));
                    check("rsp_err", 64'(rsp_err), 64'(got[EW-1]));
                end
                last_rsp_data = rsp_data;
                last_rsp_err  = rsp_err;
                busy = 1'b0;
            end

            prev_valid = rsp_valid;
            prev_ready = rsp_ready;
            prev_data  = rsp_data;
            prev_id    = rsp_id;
            prev_err   = rsp_err;
        end
        done_prev = mul_done;
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_valid[i]    = 1'b1;
    endtask

    task automatic step(output logic [NR-1:0] gr);
        @(negedge clk);
        gr = req_ready & req_valid;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~gr;
    endtask

    task automatic issue(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [NR-1:0] gr;
        int n;
        n = 0;
        @(posedge clk);
        #1;
        set_req(i, a, b);
        do begin
            step(gr);
            n++;
        end while (!gr[i] && n < 300);
        if (!gr[i]) bound_fail("grant_wait");
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy || exp_q.size() != 0) bound_fail("drain");
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
        check({tag, "_rsp_id"}, 64'(rsp_id), 64'(0));
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
        check({tag, "_mul_start"}, 64'(mul_start), 64'(0));
        check({tag, "_mul_a"}, 64'(mul_a), 64'(0));
        check({tag, "_mul_b"}, 64'(mul_b), 64'(0));
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_state_idle"}, 64'(fsm_state), 64'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");
    endtask

    task automatic random_phase(input int target);
        logic [NR-1:0] gr;
        int got_n;
        int n;
        got_n = 0;
        n = 0;
        @(posedge clk);
        #1;
        while (got_n < target && n < 5000) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) set_req(i, N'($urandom), N'($urandom));
            end
            step(gr);
            n++;
            got_n += $countones(gr);
        end
        req_valid = '0;
        if (got_n < target) bound_fail("random_phase");
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [NR-1:0] gr;
        int n;
        int got_n;
        int rr_exp[7];
        int rst_exp[2];
        rr_exp  = '{0, 1, 2, 3, 0, 1, 3};
        rst_exp = '{0, 2};

        do_reset();

        // single requests
        issue(0, N'(-7), N'(3));
        wait_drain(100);
        check("single_neg_product", 64'(last_rsp_data), 64'(8'hEB));
        issue(0, N'(6), N'(4));
        wait_drain(100);
        check("single_pos_product", 64'(last_rsp_data), 64'(8'd24));

        // round robin from a fresh pointer
        do_reset();
        grant_log.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) set_req(i, N'(i + 1), N'(-(i + 2)));
        n = 0;
        got_n = 0;
        while (got_n < 7 && n < 500) begin
            step(gr);
            n++;
            if (gr != '0) begin
                got_n++;
                if (got_n < 5) begin
                    for (int i = 0; i < NR; i++) if (gr[i]) set_req(i, N'($urandom), N'($urandom));
                end else if (got_n == 5) begin
                    req_valid = 4'b1010;
                end
            end
        end
        if (got_n < 7) bound_fail("rr_grants");
        wait_drain(100);
        check("rr_count", 64'(grant_log.size()), 64'(7));
        for (int k = 0; k < 7; k++) begin
            if (k < grant_log.size()) check("rr_order", 64'(grant_log[k]), 64'(rr_exp[k]));
        end

        // backpressure: five cycles held in RESP, handshake in the sixth
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        issue(1, N'(5), N'(-3));
        @(posedge clk);
        #1;
        set_req(3, N'(2), N'(7));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 100);
        if (!rsp_valid) bound_fail("bp_rsp_valid");
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        n = 0;
        do begin
            step(gr);
            n++;
        end while (!gr[3] && n < 100);
        if (!gr[3]) bound_fail("bp_next_grant");
        wait_drain(100);

        // random traffic, pulse done
        rand_ready = 1'b1;
        random_phase(30);
        @(posedge clk);
        #1;
        rand_ready = 1'b0;
        rsp_ready  = 1'b1;
        wait_drain(200);

        // random traffic, level done
        done_mode  = M_LEVEL;
        rand_ready = 1'b1;
        random_phase(30);
        @(posedge clk);
        #1;
        rand_ready = 1'b0;
        rsp_ready  = 1'b1;
        wait_drain(200);
        done_mode = M_PULSE;

        // reset in the middle of WAIT
        issue(1, N'(3), N'(3));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_wait_reset");
        grant_log.delete();
        @(posedge clk);
        #1;
        set_req(0, N'(-8), N'(-8));
        set_req(2, N'(7), N'(-8));
        n = 0;
        got_n = 0;
        while (got_n < 2 && n < 200) begin
            step(gr);
            n++;
            got_n += $countones(gr);
        end
        if (got_n < 2) bound_fail("rst_grants");
        wait_drain(100);
        check("rst_grant_count", 64'(grant_log.size()), 64'(2));
        for (int k = 0; k < 2; k++) begin
            if (k < grant_log.size()) check("rst_grant_order", 64'(grant_log[k]), 64'(rst_exp[k]));
        end

        // multiplier never answers
        done_mode = M_NEVER;
        issue(2, N'(4), N'(-5));
`ifdef BOOTH_ARB_TIMEOUT_EN
        wait_drain(200);
        check("timeout_data", 64'(last_rsp_data), 64'(0));
        check("timeout_err", 64'(last_rsp_err), 64'(1));
        done_mode = M_PULSE;
`else
        repeat (100) @(negedge clk);
        check("no_timeout_valid", 64'(rsp_valid), 64'(0));
        check("no_timeout_state", 64'(fsm_state), 64'(2));
        done_mode = M_PULSE;
        do_reset();
`endif

        // traffic still flows afterwards
        issue(3, N'(-1), N'(-1));
        wait_drain(100);
        check("final_product", 64'(last_rsp_data), 64'(8'd1));

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        check("one_rsp_per_accept", 64'(rsp_count), 64'(acc_count));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        mismatched++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
Shares one N-bit signed Booth multiplier (`top`: clk, start, a, b, data_out, done) among NUM_REQ requesters. Arbitration is round-robin. The block latches the granted operands, pulses `start`, and waits for `done`. It then returns the 2N-bit product with the requester ID through a valid/ready response channel. It sits between client datapaths and the single multiplier instance.

Parameters:
- N, 4, operand width in bits; product is 2N.
- NUM_REQ, 4, number of requesters (≥2).
- ID_W, $clog2(NUM_REQ), width of the requester index.
- TIMEOUT_CYCLES, 64, WAIT-state watchdog limit; used only with BOOTH_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*N  packed signed multiplicands; requester i at [i*N +: N].
- req_b  in  NUM_REQ*N  packed signed multipliers, same packing.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  2N  signed product.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_err  out  1  timeout flag; tied 0 without the macro.
- mul_start  out  1  to multiplier start.
- mul_a  out  N  to multiplier a.
- mul_b  out  N  to multiplier b.
- mul_data_out  in  2N  from multiplier data_out.
- mul_done  in  1  from multiplier done; may be a pulse or a held level.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a clk edge), including mid-operation:
  - state returns to IDLE;
  - mul_start, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, rsp_err all go to 0;
  - rr pointer is set to NUM_REQ-1, so requester 0 has first priority;
  - done_q is cleared.
  - An in-flight multiplier result is discarded.
- done_q registers mul_done every cycle. The done event is mul_done=1 && done_q=0 (rising edge), so a held-high done is counted once.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching from rr+1 upward with wrap-around.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - At the edge: latch req_a/req_b slice g into mul_a/mul_b, latch g into an internal id, set rr=g, go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE:
  - mul_start=1 for exactly this one cycle; mul_a/mul_b already stable.
  - Go to WAIT.
- WAIT:
  - mul_a/mul_b stay held until leaving this state.
  - On a done event: capture mul_data_out into rsp_data, id into rsp_id, rsp_err=0, go to RESP.
  - A done event in the same cycle as mul_start is impossible because start is in ISSUE. A done edge seen in ISSUE is ignored.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are stable until handshake.
  - On rsp_valid && rsp_ready: rsp_valid=0 at the next edge, go to IDLE.
  - No request is accepted while in RESP. A new grant happens, at the earliest, in the IDLE cycle after the handshake.
- req_ready is 0 in every state except IDLE.
- Latency: accept at cycle T; mul_start at T+1. rsp_valid rises one cycle after the cycle in which the done edge is sampled.
- Minimum issue interval: 4 cycles plus the multiplier latency.
- Arithmetic: the block performs none. Operands and product pass through unmodified in two's complement.
- Simultaneous requests are resolved purely by round-robin. A requester that drops req_valid before its grant loses nothing.

Optional Feature:
- Macro: BOOTH_ARB_TIMEOUT_EN.
- Defined:
  - a WAIT counter clears on ISSUE and increments each WAIT cycle;
  - when the count reaches TIMEOUT_CYCLES with no done event, go to RESP with rsp_data=0, rsp_err=1, rsp_id=id;
  - a done event in the same cycle as the timeout takes precedence (normal result, rsp_err=0).
- Undefined:
  - no counter; WAIT persists until a done event;
  - rsp_err is constant 0.

Test Plan:
- Single request: req 0 with a=-7, b=3 (behavioural Booth model, 4-cycle latency) -> one mul_start pulse. Then rsp_valid with rsp_data=8'hEB (-21), rsp_id=0, rsp_err=0. Check a=6, b=4 -> 24 the same way.
- Round-robin: all four req_valid held high with distinct operands, rsp_ready=1 -> grant order 0,1,2,3,0. Each product is correct and carries the matching rsp_id. Then only reqs 1 and 3 are valid after the last grant to 0 -> order 1,3.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; req_ready all 0; no mul_start. Handshake on cycle 6, then IDLE.
- Level done: the model holds done high until the next start -> exactly one result per request, none duplicated.
- Reset mid-WAIT: rst_n=0 for one edge -> next cycle all outputs are 0 and state is IDLE. A following simultaneous request from reqs 0 and 2 grants 0 first.
- Timeout (macro defined): the model never raises done -> exactly TIMEOUT_CYCLES=64 WAIT cycles, then rsp_valid=1, rsp_err=1, rsp_data=0. With the macro undefined, the block remains in WAIT with rsp_valid=0.
